// File: rtl/queue_fifo.sv
// Synchronous circular-buffer FIFO with registered pop data, occupancy count
// and sticky overflow/underflow flags.
module queue_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic                    pop,
    input  logic [DATA_WIDTH-1:0]   data_in,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    data_valid,
    output logic                    queue_empty,
    output logic                    queue_full,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count_next;
    logic                  pop_ok;
    logic                  push_ok;

    // A push into a full queue is still accepted when a pop frees a slot on the same edge.
    assign pop_ok  = pop && (count != '0);
    assign push_ok = push && ((count != FULL_COUNT) || pop_ok);

    always_comb begin
        count_next = count;
        if (push_ok && !pop_ok) begin
            count_next = count + CW'(1);
        end else if (!push_ok && pop_ok) begin
            count_next = count - CW'(1);
        end
    end

    // Storage has no reset; stale contents are never read before being rewritten.
    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            queue_empty <= 1'b1;
            queue_full  <= 1'b0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            data_valid <= pop_ok;
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + AW'(1);
            end
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end
            if (pop && !pop_ok) begin
                underflow <= 1'b1;
            end
            count       <= count_next;
            queue_empty <= (count_next == '0);
            queue_full  <= (count_next == FULL_COUNT);
        end
    end

endmodule
